// File: rtl/qft_phase_scheduler.sv
// qft_phase_scheduler
//   Runs the controlled-phase stage of the QFT for one target qubit j over a
//   state-vector RAM holding 2^NUM_QUBITS complex amplitudes.
//   For each control k = j+1 .. NUM_QUBITS-1 it scans every index i. Each index
//   with bits j and k both set is read, rotated by pi/2^(k-j) in the shared
//   phase-gate datapath, and written back.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start, target_sel  run request and target qubit (sampled only in IDLE)
//   busy, done, err    status; done/err are one-cycle pulses
//   mem_*              amplitude RAM (read data valid one cycle after mem_rd_en)
//   gate_*             controlled_phase_gate interface (combinational result)

`ifndef TOTAL_BITS
`define TOTAL_BITS 16
`endif

module qft_phase_scheduler #(
  parameter int NUM_QUBITS = 3,
  parameter int ADDR_W     = NUM_QUBITS,
  parameter int SEL_W      = 3,
  parameter int PI_FIXED   = 12868
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [SEL_W-1:0]           target_sel,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_rd_en,
  input  logic [2*`TOTAL_BITS-1:0]   mem_rd_data,
  output logic                       mem_wr_en,
  output logic [2*`TOTAL_BITS-1:0]   mem_wr_data,
  output logic                       gate_control_bit,
  output logic [`TOTAL_BITS-1:0]     gate_theta,
  output logic [2*`TOTAL_BITS-1:0]   gate_target_in,
  input  logic [2*`TOTAL_BITS-1:0]   gate_target_out
);

  localparam int TW = `TOTAL_BITS;
  localparam int DW = 2 * TW;
  localparam logic signed [TW-1:0] PI_S = TW'(PI_FIXED);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  j_q, j_d;
  logic [SEL_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic              err_q, err_d;
  logic [DW-1:0]     wb_q, wb_d;

  logic              last_i;
  logic              last_k;
  logic              adv_done;
  logic [ADDR_W-1:0] adv_i;
  logic [SEL_W-1:0]  adv_k;
  logic [ADDR_W-1:0] j_mask;
  logic [ADDR_W-1:0] k_mask;
  logic              pair_hit;
  logic [SEL_W-1:0]  shamt;
  logic              sel_invalid;
  logic              sel_last;

  // Index/control bookkeeping shared by SCAN (no hit) and WB. On the final
  // (i, k) pair the counters hold instead of wrapping.
  always_comb begin
    last_i   = (i_q == {ADDR_W{1'b1}});
    last_k   = (k_q == SEL_W'(NUM_QUBITS - 1));
    adv_done = last_i && last_k;
    adv_i    = i_q;
    adv_k    = k_q;
    if (!adv_done) begin
      if (last_i) begin
        adv_i = '0;
        adv_k = k_q + SEL_W'(1);
      end else begin
        adv_i = i_q + ADDR_W'(1);
      end
    end
  end

  // Pair qualification and rotation angle pi/2^(k-j).
  always_comb begin
    j_mask      = ADDR_W'(1) << j_q;
    k_mask      = ADDR_W'(1) << k_q;
    pair_hit    = (|(i_q & j_mask)) && (|(i_q & k_mask));
    shamt       = k_q - j_q;
    sel_invalid = (32'(target_sel) >= NUM_QUBITS);
    sel_last    = (32'(target_sel) == NUM_QUBITS - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
      err_q   <= 1'b0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      i_q     <= i_d;
      err_q   <= err_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    j_d              = j_q;
    k_d              = k_q;
    i_d              = i_q;
    err_d            = err_q;
    wb_d             = wb_q;
    busy             = (state_q != S_IDLE);
    done             = 1'b0;
    err              = 1'b0;
    mem_addr         = '0;
    mem_rd_en        = 1'b0;
    mem_wr_en        = 1'b0;
    mem_wr_data      = '0;
    gate_control_bit = 1'b0;
    gate_theta       = '0;
    gate_target_in   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (sel_invalid) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (sel_last) begin
            state_d = S_DONE;
          end else begin
            j_d     = target_sel;
            k_d     = target_sel + SEL_W'(1);
            i_d     = '0;
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        mem_addr = i_q;
        if (pair_hit) begin
          mem_rd_en = 1'b1;
          state_d   = S_EXEC;
        end else begin
          i_d     = adv_i;
          k_d     = adv_k;
          state_d = adv_done ? S_DONE : S_SCAN;
        end
      end

      S_EXEC: begin
        gate_control_bit = 1'b1;
        gate_theta       = PI_S >>> shamt;
        gate_target_in   = mem_rd_data;
        wb_d             = gate_target_out;
        state_d          = S_WB;
      end

      S_WB: begin
        mem_addr    = i_q;
        mem_wr_en   = 1'b1;
        mem_wr_data = wb_q;
        i_d         = adv_i;
        k_d         = adv_k;
        state_d     = adv_done ? S_DONE : S_SCAN;
      end

      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_qft_phase_scheduler.sv
// Testbench for qft_phase_scheduler (N=3). Holds a RAM, a real-valued phase
// gate and a per-cycle expected trace built from the scan/advance rules.

`timescale 1ns/1ps

module tb_qft_phase_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  target_sel;
  logic        busy, done, err;
  logic [2:0]  mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_rd_data, mem_wr_data;
  logic        gate_control_bit;
  logic [15:0] gate_theta;
  logic [31:0] gate_target_in, gate_target_out;

  qft_phase_scheduler #(
    .NUM_QUBITS(3), .ADDR_W(3), .SEL_W(3), .PI_FIXED(12868)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target_sel(target_sel),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .gate_control_bit(gate_control_bit), .gate_theta(gate_theta),
    .gate_target_in(gate_target_in), .gate_target_out(gate_target_out)
  );

  localparam logic [31:0] ONE = 32'h1000_0000;

  typedef struct {
    logic        busy, done, err, rd, wr, ctrl;
    logic [2:0]  addr;
    logic        chkAddr;
    logic [15:0] theta;
    logic [31:0] tin, wdata;
    int          k;
  } rec_t;

  rec_t        expQ[$];
  logic [31:0] ram [0:7];
  logic [31:0] model [0:7];
  logic        loadReq;
  logic [31:0] loadVal;
  logic        traceOn;
  int          vectors, miscompares;
  int          cyc, c0, doneLat, wrCount, rdCount, curJ;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Amplitude RAM with one-cycle read latency
  always @(posedge clk) begin
    if (loadReq) begin
      for (int a = 0; a < 8; a++) ram[a] <= loadVal;
    end else begin
      if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end
    if (mem_wr_en) wrCount <= wrCount + 1;
    if (mem_rd_en) rdCount <= rdCount + 1;
  end

  // Rotate {re,im} in Q4.12 by theta radians, rounded to nearest
  function automatic logic [31:0] gateFn(input logic [31:0] a, input logic [15:0] th);
    real t, c, s, re, im, nr, ni;
    int r1, r2;
    logic [31:0] w1, w2;
    t  = $itor($signed(th)) / 4096.0;
    c  = $cos(t);
    s  = $sin(t);
    re = $itor($signed(a[31:16]));
    im = $itor($signed(a[15:0]));
    nr = re * c - im * s;
    ni = re * s + im * c;
    r1 = $rtoi((nr >= 0.0) ? nr + 0.5 : nr - 0.5);
    r2 = $rtoi((ni >= 0.0) ? ni + 0.5 : ni - 0.5);
    w1 = r1;
    w2 = r2;
    return {w1[15:0], w2[15:0]};
  endfunction

  always_comb begin
    gate_target_out = gate_target_in;
    if (gate_control_bit) gate_target_out = gateFn(gate_target_in, gate_theta);
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmpTol(input string nm, input logic [15:0] act, input int exp, input int tol);
    int a, d;
    a = $signed(act);
    d = (a > exp) ? a - exp : exp - a;
    vectors++;
    if (d > tol) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d +/- %0d", nm, a, exp, tol);
    end
  endtask

  function automatic rec_t blankRec();
    rec_t r;
    r.busy = 1'b1; r.done = 1'b0; r.err = 1'b0; r.rd = 1'b0; r.wr = 1'b0;
    r.ctrl = 1'b0; r.addr = '0; r.chkAddr = 1'b1; r.theta = '0;
    r.tin = '0; r.wdata = '0; r.k = 0;
    return r;
  endfunction

  // Expected cycle-by-cycle behaviour of one run, from the scan rules
  task automatic buildTrace(input int j);
    rec_t r;
    logic [15:0] th;
    logic [31:0] w;
    if (j < 2) begin
      for (int k = j + 1; k < 3; k++) begin
        th = 16'(12868 / (1 << (k - j)));
        for (int i = 0; i < 8; i++) begin
          r = blankRec();
          r.addr = 3'(i);
          r.k = k;
          if (((i >> j) & 1) == 1 && ((i >> k) & 1) == 1) begin
            r.rd = 1'b1;
            expQ.push_back(r);
            r = blankRec();
            r.ctrl = 1'b1; r.theta = th; r.tin = model[i]; r.k = k;
            expQ.push_back(r);
            w = gateFn(model[i], th);
            model[i] = w;
            r = blankRec();
            r.wr = 1'b1; r.addr = 3'(i); r.wdata = w; r.k = k;
            expQ.push_back(r);
          end else begin
            r.chkAddr = 1'b0;
            expQ.push_back(r);
          end
        end
      end
    end
    r = blankRec();
    r.done = 1'b1;
    r.err = (j >= 3);
    expQ.push_back(r);
  endtask

  task automatic checkOutput(input rec_t r);
    cmp("busy", busy, r.busy);
    cmp("done", done, r.done);
    cmp("err", err, r.err);
    cmp("rd_en", mem_rd_en, r.rd);
    cmp("wr_en", mem_wr_en, r.wr);
    cmp("ctrl", gate_control_bit, r.ctrl);
    cmp("theta", gate_theta, r.theta);
    if (r.chkAddr) cmp("addr", mem_addr, r.addr);
    if (r.ctrl) cmp("gate_in", gate_target_in, r.tin);
    if (r.wr) cmp("wr_data", mem_wr_data, r.wdata);
    if (r.ctrl && curJ == 0) cmp("theta_lit", gate_theta, (r.k == 1) ? 32'd6434 : 32'd3217);
    if (r.done && done) doneLat = cyc - c0 + 1;
  endtask

  task automatic checkIdle();
    cmp("idle_busy", busy, 0);
    cmp("idle_done", done, 0);
    cmp("idle_rd", mem_rd_en, 0);
    cmp("idle_wr", mem_wr_en, 0);
    cmp("idle_addr", mem_addr, 0);
    cmp("idle_theta", gate_theta, 0);
  endtask

  // Single compare process
  always @(negedge clk) begin
    if (traceOn && rst_n) begin
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
      else checkIdle();
    end
  end

  task automatic loadRam(input logic [31:0] v);
    @(negedge clk);
    loadVal = v;
    loadReq = 1'b1;
    @(posedge clk);
    #1 loadReq = 1'b0;
    for (int a = 0; a < 8; a++) model[a] = v;
  endtask

  task automatic applyStimulus(input int j);
    @(negedge clk);
    traceOn = 1'b0;
    start = 1'b1;
    target_sel = 3'(j);
    curJ = j;
    doneLat = -1;
    buildTrace(j);
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    traceOn = 1'b1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d records left, required 0", expQ.size());
      expQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkTest1Mem(input string tag);
    cmpTol({tag, " m3.re"}, ram[3][31:16], 0, 2);
    cmpTol({tag, " m3.im"}, ram[3][15:0], 4096, 2);
    cmpTol({tag, " m5.re"}, ram[5][31:16], 2896, 2);
    cmpTol({tag, " m5.im"}, ram[5][15:0], 2896, 2);
    cmpTol({tag, " m7.re"}, ram[7][31:16], -2896, 4);
    cmpTol({tag, " m7.im"}, ram[7][15:0], 2896, 4);
    cmp({tag, " m0"}, ram[0], ONE);
    cmp({tag, " m1"}, ram[1], ONE);
    cmp({tag, " m2"}, ram[2], ONE);
    cmp({tag, " m4"}, ram[4], ONE);
    cmp({tag, " m6"}, ram[6], ONE);
    for (int a = 0; a < 8; a++) cmp({tag, " model"}, ram[a], model[a]);
  endtask

  initial begin
    int w0, r0;
    vectors = 0; miscompares = 0; cyc = 0; c0 = 0; doneLat = -1;
    wrCount = 0; rdCount = 0; curJ = 0;
    traceOn = 1'b0; loadReq = 1'b0; loadVal = '0;
    rst_n = 1'b0; start = 1'b0; target_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst busy", busy, 0);
    cmp("rst done", done, 0);
    cmp("rst err", err, 0);
    cmp("rst rd", mem_rd_en, 0);
    cmp("rst wr", mem_wr_en, 0);
    cmp("rst addr", mem_addr, 0);
    cmp("rst theta", gate_theta, 0);
    cmp("rst ctrl", gate_control_bit, 0);
    cmp("rst wdata", mem_wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1 and 2: j=0 over all-(4096,0) memory
    loadRam(ONE);
    w0 = wrCount;
    applyStimulus(0);
    waitDrain();
    cmp("t1 latency", doneLat, 25);
    cmp("t1 writes", wrCount - w0, 4);
    checkTest1Mem("t1");

    // Test 3: j=N-1, no controls
    w0 = wrCount; r0 = rdCount;
    applyStimulus(2);
    waitDrain();
    cmp("t3 latency", doneLat, 1);
    cmp("t3 writes", wrCount - w0, 0);
    cmp("t3 reads", rdCount - r0, 0);

    // Test 4: invalid target
    w0 = wrCount; r0 = rdCount;
    applyStimulus(5);
    waitDrain();
    cmp("t4 latency", doneLat, 1);
    cmp("t4 writes", wrCount - w0, 0);
    cmp("t4 reads", rdCount - r0, 0);
    cmp("t4 busy", busy, 0);

    // Test 5: second start 3 cycles into a run
    loadRam(ONE);
    w0 = wrCount;
    applyStimulus(0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    target_sel = 3'd1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDrain();
    cmp("t5 latency", doneLat, 25);
    cmp("t5 writes", wrCount - w0, 4);
    checkTest1Mem("t5");

    // Test 6: reset during the first EXEC
    loadRam(ONE);
    traceOn = 1'b0;
    w0 = wrCount;
    @(negedge clk);
    start = 1'b1;
    target_sel = 3'd0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    cmp("t6 in exec", gate_control_bit, 1);
    rst_n = 1'b0;
    #1;
    cmp("t6 busy", busy, 0);
    cmp("t6 ctrl", gate_control_bit, 0);
    cmp("t6 theta", gate_theta, 0);
    cmp("t6 wr", mem_wr_en, 0);
    cmp("t6 rd", mem_rd_en, 0);
    cmp("t6 addr", mem_addr, 0);
    repeat (3) @(posedge clk);
    #1;
    cmp("t6 m3 kept", ram[3], ONE);
    cmp("t6 writes", wrCount - w0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) model[a] = ONE;
    w0 = wrCount;
    applyStimulus(0);
    waitDrain();
    cmp("t6 latency", doneLat, 25);
    cmp("t6 rerun writes", wrCount - w0, 4);
    checkTest1Mem("t6");

    traceOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
